// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Modular increment: n-1 wraps to 0.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotate-and-pick: first asserted request at or after ptr, modulo NUM_REQ.
// Zero latency; no state, no backpressure.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int cur;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cur   = int'(ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[IDX_W'(cur)]) begin
        found = 1'b1;
        idx   = IDX_W'(cur);
      end
      cur = next_idx(cur, NUM_REQ);
    end
  end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin share of one FIFO write port among NUM_REQ valid/ready producers, bursts up to MAX_BURST.
// Zero latency (beat written on the accepting edge); fifo_full drops every req_ready and stalls the owner in place.
module fifo_rr_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          grant_active,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [IDX_W-1:0] pick_idx, sel;
  logic             pick_found, sel_vld, sel_req_vld, grant_ok, xfer, last_beat;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_vld      = (state == BURST) || pick_found;
    sel          = (state == BURST) ? owner : pick_idx;
    grant_ok     = rst_n && sel_vld && !fifo_full;
    sel_req_vld  = 1'b0;
    req_ready    = '0;
    fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_vld && (sel == IDX_W'(i))) begin
        sel_req_vld  = req_valid[i];
        req_ready[i] = grant_ok;
        fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    xfer      = grant_ok && sel_req_vld;
    fifo_w_en = xfer;
  end

  assign last_beat = (32'(beat_cnt) + 32'd1 == 32'(MAX_BURST));

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (MAX_BURST == 1) begin
            rr_ptr_nxt = IDX_W'(next_idx(int'(sel), NUM_REQ));
          end else begin
            state_nxt    = BURST;
            owner_nxt    = sel;
            beat_cnt_nxt = CNT_W'(1);
          end
        end
      end
      BURST: begin
        // Owner going idle releases the port at once, costing one empty cycle.
        if (!sel_req_vld || (xfer && last_beat)) begin
          state_nxt    = IDLE;
          rr_ptr_nxt   = IDX_W'(next_idx(int'(owner), NUM_REQ));
          beat_cnt_nxt = '0;
        end else if (xfer) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  assign grant_active = (state == BURST);
  assign grant_id     = owner;

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Table-driven directed vectors, a MAX_BURST=1 rotation sequence, and a random scoreboard stress.
module tb_fifo_rr_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_w_en;
  logic [7:0]  fifo_data_in;
  logic        grant_active;
  logic [1:0]  grant_id;

  logic [2:0]  b_valid;
  logic [23:0] b_data;
  logic [2:0]  b_ready;
  logic        b_full;
  logic        b_wen;
  logic [7:0]  b_din;
  logic        b_gact;
  logic [1:0]  b_gid;

  int tests = 0;
  int fails = 0;

  fifo_rr_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_w_en(fifo_w_en),
    .fifo_data_in(fifo_data_in), .grant_active(grant_active), .grant_id(grant_id)
  );

  fifo_rr_write_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_data(b_data),
    .req_ready(b_ready), .fifo_full(b_full), .fifo_w_en(b_wen),
    .fifo_data_in(b_din), .grant_active(b_gact), .grant_id(b_gid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       full;
    logic [3:0] rdy;
    logic       wen;
    logic       chk_d;
    logic [7:0] d;
    logic       gact;
    logic [1:0] gid;
  } vec_t;

  vec_t tbl [26];

  // Stress state
  logic [3:0] pv;
  logic [3:0] hs;
  logic [5:0] seq [4];
  int         waitc [4];
  logic [7:0] sbq [4][$];
  int         occ;
  logic [1:0] wid;
  logic [7:0] exp_d;

  initial begin
    // rst, valid, full | ready, wen, chk_d, data, gact, gid
    tbl[0]  = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 4'hF, 1'b0, 4'h1, 1'b1, 1'b1, 8'hA0, 1'b0, 2'd0};
    tbl[2]  = '{1'b1, 4'hF, 1'b0, 4'h1, 1'b1, 1'b1, 8'hA0, 1'b1, 2'd0};
    tbl[3]  = '{1'b1, 4'hF, 1'b0, 4'h1, 1'b1, 1'b1, 8'hA0, 1'b1, 2'd0};
    tbl[4]  = '{1'b1, 4'hF, 1'b0, 4'h1, 1'b1, 1'b1, 8'hA0, 1'b1, 2'd0};
    tbl[5]  = '{1'b1, 4'hF, 1'b0, 4'h2, 1'b1, 1'b1, 8'hA1, 1'b0, 2'd0};
    tbl[6]  = '{1'b1, 4'hF, 1'b0, 4'h2, 1'b1, 1'b1, 8'hA1, 1'b1, 2'd1};
    tbl[7]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd1};
    tbl[8]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd1};
    tbl[9]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd1};
    tbl[10] = '{1'b1, 4'hF, 1'b0, 4'h2, 1'b1, 1'b1, 8'hA1, 1'b1, 2'd1};
    tbl[11] = '{1'b1, 4'hF, 1'b0, 4'h2, 1'b1, 1'b1, 8'hA1, 1'b1, 2'd1};
    tbl[12] = '{1'b1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 8'hA0, 1'b0, 2'd1};
    tbl[13] = '{1'b1, 4'h0, 1'b0, 4'h1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0};
    tbl[14] = '{1'b1, 4'h4, 1'b0, 4'h4, 1'b1, 1'b1, 8'hA2, 1'b0, 2'd0};
    tbl[15] = '{1'b1, 4'h4, 1'b0, 4'h4, 1'b1, 1'b1, 8'hA2, 1'b1, 2'd2};
    tbl[16] = '{1'b1, 4'h1, 1'b0, 4'h4, 1'b0, 1'b1, 8'hA2, 1'b1, 2'd2};
    tbl[17] = '{1'b1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 8'hA0, 1'b0, 2'd2};
    tbl[18] = '{1'b1, 4'h8, 1'b1, 4'h0, 1'b0, 1'b1, 8'hA0, 1'b1, 2'd0};
    tbl[19] = '{1'b1, 4'h8, 1'b1, 4'h0, 1'b0, 1'b1, 8'hA3, 1'b0, 2'd0};
    tbl[20] = '{1'b1, 4'h8, 1'b0, 4'h8, 1'b1, 1'b1, 8'hA3, 1'b0, 2'd0};
    tbl[21] = '{1'b1, 4'h8, 1'b0, 4'h8, 1'b1, 1'b1, 8'hA3, 1'b1, 2'd3};
    tbl[22] = '{1'b0, 4'h8, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd3};
    tbl[23] = '{1'b1, 4'h9, 1'b0, 4'h1, 1'b1, 1'b1, 8'hA0, 1'b0, 2'd0};
    tbl[24] = '{1'b1, 4'h0, 1'b0, 4'h1, 1'b0, 1'b1, 8'hA0, 1'b1, 2'd0};
    tbl[25] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 8'h00, 1'b0, 2'd0};

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = 32'hA3A2A1A0;
    fifo_full = 1'b0;
    b_valid   = '0;
    b_data    = 24'hB2B1B0;
    b_full    = 1'b0;
    repeat (2) @(posedge clk);

    // Directed table: bursts, full stall, early release, reset mid-burst
    for (int r = 0; r < 26; r++) begin
      @(posedge clk); #1;
      rst_n     = tbl[r].rst;
      req_valid = tbl[r].v;
      fifo_full = tbl[r].full;
      @(negedge clk);
      chk($sformatf("row%0d_ready", r), 32'(req_ready), 32'(tbl[r].rdy));
      chk($sformatf("row%0d_wen", r), 32'(fifo_w_en), 32'(tbl[r].wen));
      chk($sformatf("row%0d_gact", r), 32'(grant_active), 32'(tbl[r].gact));
      chk($sformatf("row%0d_gid", r), 32'(grant_id), 32'(tbl[r].gid));
      if (tbl[r].chk_d) chk($sformatf("row%0d_data", r), 32'(fifo_data_in), 32'(tbl[r].d));
    end

    // MAX_BURST=1, NUM_REQ=3: strict per-beat rotation with wrap
    @(posedge clk); #1;
    rst_n     = 1'b0;
    req_valid = '0;
    b_valid   = 3'b111;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      b_full = (k == 7);
      @(negedge clk);
      if (k == 7) begin
        chk("b_full_ready", 32'(b_ready), 32'h0);
        chk("b_full_wen", 32'(b_wen), 32'h0);
      end else begin
        chk($sformatf("b%0d_ready", k), 32'(b_ready), 32'(1 << ((k == 8) ? 1 : k % 3)));
        chk($sformatf("b%0d_wen", k), 32'(b_wen), 32'h1);
        chk($sformatf("b%0d_data", k), 32'(b_din), 32'(8'hB0 + ((k == 8) ? 1 : k % 3)));
      end
      chk($sformatf("b%0d_gact", k), 32'(b_gact), 32'h0);
    end

    // Random stress against per-producer scoreboard and an 8-deep FIFO occupancy model
    @(posedge clk); #1;
    b_valid   = '0;
    b_full    = 1'b0;
    rst_n     = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pv    = '0;
    hs    = '0;
    occ   = 0;
    for (int i = 0; i < 4; i++) begin
      seq[i]   = '0;
      waitc[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) begin
          seq[i] = seq[i] + 6'd1;
          pv[i]  = 1'b0;
        end
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i]    = 1'b1;
          waitc[i] = 0;
          sbq[i].push_back({2'(i), seq[i]});
        end
        req_data[i*8 +: 8] = {2'(i), seq[i]};
      end
      if (occ > 0 && $urandom_range(0, 1) == 0) occ--;
      fifo_full = (occ >= 8);
      req_valid = pv;
      @(negedge clk);
      hs = req_valid & req_ready;
      if (fifo_w_en) begin
        chk("stress_wen_while_full", 32'(fifo_full), 32'h0);
        wid = fifo_data_in[7:6];
        chk("stress_hs_onehot", 32'(hs), 32'(1 << wid));
        if (sbq[wid].size() == 0) begin
          chk("stress_sb_empty", 32'(sbq[wid].size()), 32'h1);
        end else begin
          exp_d = sbq[wid].pop_front();
          chk("stress_order", 32'(fifo_data_in), 32'(exp_d));
        end
        occ++;
      end else begin
        chk("stress_no_hs", 32'(hs), 32'h0);
      end
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) begin
          tests++;
          if (waitc[i] > 15) begin
            fails++;
            $display("FAIL stress_wait p%0d: waited %0d allowed 15", i, waitc[i]);
          end
        end else if (pv[i] && !fifo_full) begin
          waitc[i]++;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stress_left_p%0d", i), 32'(sbq[i].size()), 32'(pv[i] && !hs[i]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
